// File: rtl/freq_est_ctrl_pkg.sv
// Shared types and constants for the frequency-estimate controller.
// Build option: FE_CTRL_TIMEOUT_EN (see freq_est_ctrl.sv).
package fe_ctrl_pkg;

   localparam int unsigned SAMPLE_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_WAIT_PEAK,
      ST_REPLAY,
      ST_WAIT_CNT,
      ST_DONE
   } fe_state_e;

   // Threshold = peak scaled down by a power of two, sign preserved.
   function automatic logic signed [SAMPLE_W-1:0] fe_thresh(
      input logic signed [SAMPLE_W-1:0] peak,
      input int unsigned                shift
   );
      return peak >>> shift;
   endfunction

endpackage

// File: rtl/freq_est_ctrl_if.sv
// Handshake/data bundle between the controller, the sample source,
// peak_find and freq_est. err exists only with FE_CTRL_TIMEOUT_EN.
interface freq_est_ctrl_if;
   import fe_ctrl_pkg::*;

   logic                       start;
   logic signed [SAMPLE_W-1:0] x;
   logic                       x_v;
   logic                       in_ready;
   logic        [SAMPLE_W-1:0] pf_x;
   logic                       pf_v;
   logic signed [SAMPLE_W-1:0] pf_peak;
   logic                       pf_vout;
   logic        [SAMPLE_W-1:0] fe_x;
   logic                       fe_v;
   logic signed [SAMPLE_W-1:0] fe_threshold;
   logic        [SAMPLE_W-1:0] fe_count;
   logic                       fe_vout;
   logic        [SAMPLE_W-1:0] count;
   logic                       count_v;
   logic                       busy;
`ifdef FE_CTRL_TIMEOUT_EN
   logic                       err;
`endif

   modport master (
`ifdef FE_CTRL_TIMEOUT_EN
      input  err,
`endif
      output start, x, x_v, pf_peak, pf_vout, fe_count, fe_vout,
      input  in_ready, pf_x, pf_v, fe_x, fe_v, fe_threshold, count, count_v, busy
   );

   modport slave (
`ifdef FE_CTRL_TIMEOUT_EN
      output err,
`endif
      input  start, x, x_v, pf_peak, pf_vout, fe_count, fe_vout,
      output in_ready, pf_x, pf_v, fe_x, fe_v, fe_threshold, count, count_v, busy
   );

endinterface

// File: rtl/freq_est_ctrl_ram.sv
// Frame buffer: single clock, one write port, one registered read port.
module fe_frame_ram #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port and registered read port; contents are never cleared.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/freq_est_ctrl.sv
// Frame capture / peak / replay / count sequencer for freq_est.
// Optional build macro FE_CTRL_TIMEOUT_EN adds a wait-state watchdog and err.
module freq_est_ctrl #(
   parameter int unsigned FRAME_LEN    = 256,
   parameter int unsigned THRESH_SHIFT = 2,
   parameter int unsigned TIMEOUT      = 64
) (
   input logic           clk,
   input logic           rst,
   freq_est_ctrl_if.slave bus
);
   import fe_ctrl_pkg::*;

   localparam int unsigned ADDR_W = $clog2(FRAME_LEN);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   if (FRAME_LEN < 4 || FRAME_LEN > 4096 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_len
      $error("FRAME_LEN must be a power of two in 4..4096");
   end
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("TIMEOUT must be non-zero");
   end

   fe_state_e                  r_state;
   logic [ADDR_W-1:0]          r_wr_ptr;
   logic [ADDR_W-1:0]          r_rd_ptr;
   logic                       r_rd_done;
   logic                       r_fe_v;
   logic                       r_count_v;
   logic signed [SAMPLE_W-1:0] r_thresh;
   logic [SAMPLE_W-1:0]        r_count;
   logic                       w_accept;
   logic                       w_rd_en;
   logic [SAMPLE_W-1:0]        w_rdata;

`ifdef FE_CTRL_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0] r_to_cnt;
   logic            r_err;
`endif

   assign w_accept = (r_state == ST_CAPTURE) && bus.x_v;
   assign w_rd_en  = (r_state == ST_REPLAY) && !r_rd_done;

   fe_frame_ram #(
      .DEPTH  (FRAME_LEN),
      .ADDR_W (ADDR_W),
      .DATA_W (SAMPLE_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_accept),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.x),
      .i_re    (w_rd_en),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // Frame sequencer: state, pointers, latched threshold/count and strobes.
   // REPLAY holds one extra cycle (r_rd_done) so the last fe_v leaves the
   // RAM register before WAIT_CNT is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_done <= 1'b0;
         r_fe_v    <= 1'b0;
         r_count_v <= 1'b0;
         r_thresh  <= '0;
         r_count   <= '0;
`ifdef FE_CTRL_TIMEOUT_EN
         r_to_cnt  <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_fe_v    <= w_rd_en;
         r_count_v <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_wr_ptr <= '0;
                  r_state  <= ST_CAPTURE;
`ifdef FE_CTRL_TIMEOUT_EN
                  r_err    <= 1'b0;
`endif
               end
            end
            ST_CAPTURE: begin
               if (w_accept) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (r_wr_ptr == LAST_ADDR) begin
                     r_state <= ST_WAIT_PEAK;
`ifdef FE_CTRL_TIMEOUT_EN
                     r_to_cnt <= '0;
`endif
                  end
               end
            end
            ST_WAIT_PEAK: begin
               if (bus.pf_vout) begin
                  r_thresh  <= fe_thresh(bus.pf_peak, THRESH_SHIFT);
                  r_rd_ptr  <= '0;
                  r_rd_done <= 1'b0;
                  r_state   <= ST_REPLAY;
               end
`ifdef FE_CTRL_TIMEOUT_EN
               else if (r_to_cnt == TO_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            ST_REPLAY: begin
               if (!r_rd_done) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
                  if (r_rd_ptr == LAST_ADDR) begin
                     r_rd_done <= 1'b1;
                  end
               end else begin
                  r_state <= ST_WAIT_CNT;
`ifdef FE_CTRL_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end
            end
            ST_WAIT_CNT: begin
               if (bus.fe_vout) begin
                  r_count   <= bus.fe_count;
                  r_count_v <= 1'b1;
                  r_state   <= ST_DONE;
               end
`ifdef FE_CTRL_TIMEOUT_EN
               else if (r_to_cnt == TO_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready     = (r_state == ST_CAPTURE);
   assign bus.pf_v         = w_accept;
   assign bus.pf_x         = (r_state == ST_CAPTURE) ? bus.x : '0;
   assign bus.fe_v         = r_fe_v;
   assign bus.fe_x         = r_fe_v ? w_rdata : '0;
   assign bus.fe_threshold = r_thresh;
   assign bus.count        = r_count;
   assign bus.count_v      = r_count_v;
   assign bus.busy         = (r_state != ST_IDLE);
`ifdef FE_CTRL_TIMEOUT_EN
   assign bus.err          = r_err;
`endif

endmodule

// File: tb/tb_freq_est_ctrl.sv
// Directed bench for freq_est_ctrl with FRAME_LEN=8.
// Optional section exercises the FE_CTRL_TIMEOUT_EN watchdog.
module tb_freq_est_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] samp [8];

   always #5 clk = ~clk;

   freq_est_ctrl_if bus();

   freq_est_ctrl #(
      .FRAME_LEN    (8),
      .THRESH_SHIFT (2),
      .TIMEOUT      (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int s0, input int s1, input int s2, input int s3,
                       input int s4, input int s5, input int s6, input int s7);
      samp[0] = 16'(s0); samp[1] = 16'(s1); samp[2] = 16'(s2); samp[3] = 16'(s3);
      samp[4] = 16'(s4); samp[5] = 16'(s5); samp[6] = 16'(s6); samp[7] = 16'(s7);
   endtask

   // Start a frame and feed samp[]; gap=1 inserts an idle x_v cycle after each sample.
   task automatic capture(input bit gap, input bit restart_mid);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("in_ready_capture", 16'(bus.in_ready), 16'd1);
      for (int i = 0; i < 8; i++) begin
         bus.x   = samp[i];
         bus.x_v = 1'b1;
         if (restart_mid && i == 3) bus.start = 1'b1;
         #1;
         chk("pf_v", 16'(bus.pf_v), 16'd1);
         chk("pf_x", bus.pf_x, samp[i]);
         tick();
         bus.start = 1'b0;
         if (gap && i < 7) begin
            bus.x_v = 1'b0;
            bus.x   = 16'h7fff;
            #1;
            chk("pf_v_gap", 16'(bus.pf_v), 16'd0);
            chk("in_ready_gap", 16'(bus.in_ready), 16'd1);
            tick();
         end
      end
      bus.x_v = 1'b0;
      chk("in_ready_wait_peak", 16'(bus.in_ready), 16'd0);
      chk("busy_wait_peak", 16'(bus.busy), 16'd1);
   endtask

   // Return a peak, then check n replayed samples.
   task automatic peak_and_replay(input logic [15:0] peak, input logic [15:0] thr, input int n);
      bus.pf_peak = peak;
      bus.pf_vout = 1'b1;
      tick();
      bus.pf_vout = 1'b0;
      chk("fe_threshold", bus.fe_threshold, thr);
      chk("fe_v_first_cycle", 16'(bus.fe_v), 16'd0);
      for (int k = 0; k < n; k++) begin
         tick();
         chk("fe_v_replay", 16'(bus.fe_v), 16'd1);
         chk("fe_x_replay", bus.fe_x, samp[k]);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.x = '0; bus.x_v = 1'b0;
      bus.pf_peak = '0; bus.pf_vout = 1'b0;
      bus.fe_count = '0; bus.fe_vout = 1'b0;
      tick(); tick();
      rst = 1'b0;

      chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
      chk("rst_busy", 16'(bus.busy), 16'd0);
      chk("rst_pf_v", 16'(bus.pf_v), 16'd0);
      chk("rst_pf_x", bus.pf_x, 16'd0);
      chk("rst_fe_v", 16'(bus.fe_v), 16'd0);
      chk("rst_fe_x", bus.fe_x, 16'd0);
      chk("rst_thr", bus.fe_threshold, 16'd0);
      chk("rst_count", bus.count, 16'd0);
      chk("rst_count_v", 16'(bus.count_v), 16'd0);
`ifdef FE_CTRL_TIMEOUT_EN
      chk("rst_err", 16'(bus.err), 16'd0);
`endif

      // Frame 1: gapped capture, stray handshakes in the wrong states.
      load(0, 100, -200, 400, -300, 50, 0, -10);
      capture(1'b1, 1'b0);
      bus.x = 16'h1234; bus.x_v = 1'b1;
      #1;
      chk("pf_v_dropped", 16'(bus.pf_v), 16'd0);
      bus.fe_count = 16'd99; bus.fe_vout = 1'b1;
      tick();
      bus.x_v = 1'b0; bus.fe_vout = 1'b0;
      chk("count_v_stray", 16'(bus.count_v), 16'd0);
      chk("count_stray", bus.count, 16'd0);
      peak_and_replay(16'd400, 16'd100, 8);
      tick();
      chk("fe_v_end", 16'(bus.fe_v), 16'd0);
      bus.pf_peak = 16'hF060; bus.pf_vout = 1'b1;
      tick();
      bus.pf_vout = 1'b0;
      chk("thr_stable", bus.fe_threshold, 16'd100);
      bus.fe_count = 16'd3; bus.fe_vout = 1'b1;
      tick();
      bus.fe_vout = 1'b0;
      chk("count_v_pulse", 16'(bus.count_v), 16'd1);
      chk("count_val", bus.count, 16'd3);
      chk("busy_done", 16'(bus.busy), 16'd1);
      tick();
      chk("count_v_low", 16'(bus.count_v), 16'd0);
      chk("count_hold", bus.count, 16'd3);
      chk("busy_idle", 16'(bus.busy), 16'd0);

      // Frame 2: start ignored mid-capture, negative peak, reset mid-replay.
      load(11, -22, 33, -44, 55, -66, 77, -88);
      capture(1'b0, 1'b1);
      peak_and_replay(16'hFFF9, 16'hFFFE, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_fe_v", 16'(bus.fe_v), 16'd0);
      chk("abort_fe_x", bus.fe_x, 16'd0);
      chk("abort_thr", bus.fe_threshold, 16'd0);
      chk("abort_count", bus.count, 16'd0);
      chk("abort_busy", 16'(bus.busy), 16'd0);
      chk("abort_in_ready", 16'(bus.in_ready), 16'd0);

      // Frame 3: full frame after abort.
      load(7, -1, 32767, -32768, 5, 6, -8, 9);
      capture(1'b0, 1'b0);
      peak_and_replay(16'd1000, 16'd250, 8);
      tick();
      chk("f3_fe_v_end", 16'(bus.fe_v), 16'd0);
      bus.fe_count = 16'd5; bus.fe_vout = 1'b1;
      tick();
      bus.fe_vout = 1'b0;
      chk("f3_count_v", 16'(bus.count_v), 16'd1);
      chk("f3_count", bus.count, 16'd5);
      tick();
      chk("f3_busy", 16'(bus.busy), 16'd0);

`ifdef FE_CTRL_TIMEOUT_EN
      // Watchdog: no pf_vout.
      capture(1'b0, 1'b0);
      for (int c = 0; c < 63; c++) begin
         tick();
         chk("to_no_count_v", 16'(bus.count_v), 16'd0);
      end
      chk("to_err_early", 16'(bus.err), 16'd0);
      chk("to_busy_early", 16'(bus.busy), 16'd1);
      tick();
      chk("to_err", 16'(bus.err), 16'd1);
      chk("to_idle", 16'(bus.busy), 16'd0);
      chk("to_count_v", 16'(bus.count_v), 16'd0);
      tick();
      chk("to_err_sticky", 16'(bus.err), 16'd1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("to_err_clear", 16'(bus.err), 16'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
